// File: rtl/vga_pll_lock_sequencer.sv
`timescale 1ns/1ps
// vga_pll_lock_sequencer
//   Brings the video PLL from power-up to a verified stable lock, then
//   releases the pixel-domain reset followed by the system-domain reset.
//   A lock loss (while releasing or running) or a software relock request
//   re-resets the PLL. Bounded lock timeouts end in a sticky FAIL state.
//   Runs entirely on refclk. All outputs are registered.
//
// Ports
//   refclk         in   sole clock (50 MHz)
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock indication, asynchronous to refclk
//   relock_req     in   single-cycle pulse, restarts the sequence
//   pll_rst        out  active-high PLL reset
//   pix_rst_n      out  active-low pixel-domain reset
//   sys_rst_n      out  active-low system-domain reset
//   ready          out  high only in RUN
//   lock_fail      out  high in FAIL
//   retry_cnt      out  timeouts taken in the current acquisition
//   lock_loss_cnt  out  lock losses seen in RELEASE/RUN, saturating
//   state_o        out  RESET_PLL=0 WAIT_LOCK=1 RELEASE=2 RUN=3 FAIL=4
module vga_pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned RELEASE_GAP         = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       pix_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(RELEASE_GAP + 1);

  // Counters hold "cycles already spent - 1" style values: the transition
  // fires on the cycle where the count has reached its last value.
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(RELEASE_GAP - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          lk;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, pll_rst_d;
  logic          pix_q, pix_d;
  logic          sys_q, sys_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  assign lk = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    // Every counter restarts at zero unless the FSM stays put and counts.
    pulse_d = '0;
    stab_d  = '0;
    tmo_d   = '0;
    gap_d   = '0;

    if (relock_req) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (pulse_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
          else                       pulse_d = pulse_q + 1'b1;
        end
        ST_WAIT_LOCK: begin
          // Stable lock wins over a timeout landing on the same cycle.
          if (lk && (stab_q == STAB_LAST)) begin
            state_d = ST_RELEASE;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_RESET_PLL;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            tmo_d  = tmo_q + 1'b1;
            stab_d = lk ? stab_q + 1'b1 : '0;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lk) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            retry_d = '0;
            state_d = ST_RESET_PLL;
          end else if (state_q == ST_RELEASE) begin
            if (gap_q == GAP_LAST) state_d = ST_RUN;
            else                   gap_d   = gap_q + 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET_PLL;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register on the
    // same edge as the state change.
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    pix_d     = (state_d == ST_RELEASE) || (state_d == ST_RUN);
    sys_d     = (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= ST_RESET_PLL;
      pulse_q   <= '0;
      stab_q    <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      pix_q     <= 1'b0;
      sys_q     <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      pix_q     <= pix_d;
      sys_q     <= sys_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign pix_rst_n     = pix_q;
  assign sys_rst_n     = sys_q;
  assign ready         = ready_q;
  assign lock_fail     = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_vga_pll_lock_sequencer.sv
`timescale 1ns/1ps
// Testbench for vga_pll_lock_sequencer with short parameters.
module tb_vga_pll_lock_sequencer;

  localparam int RST  = 4;
  localparam int STAB = 8;
  localparam int TMO  = 32;
  localparam int MAXR = 2;
  localparam int GAP  = 2;

  localparam logic [19:0] RST_VEC = {1'b1, 19'b0};

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       pix_rst_n;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;
  logic [19:0] dut_vec;

  int checks;
  int errors;

  vga_pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST),
    .LOCK_STABLE_CYCLES  (STAB),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES         (MAXR),
    .RELEASE_GAP         (GAP)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .pix_rst_n     (pix_rst_n),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .lock_fail     (lock_fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state_o       (state_o)
  );

  assign dut_vec = {pll_rst, pix_rst_n, sys_rst_n, ready, lock_fail,
                    retry_cnt, lock_loss_cnt, state_o};

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: phase number, cycles spent in phase, run length of
  // synchronized lock, retry and loss counts, all as plain integers.
  int m_s1, m_s2, m_phase, m_age, m_run, m_retries, m_losses;

  always @(posedge refclk or negedge rst_n) begin : ref_model
    int ph, age, run, rtr, los;
    bit lkm;
    if (!rst_n) begin
      m_s1 <= 0; m_s2 <= 0; m_phase <= 0; m_age <= 0;
      m_run <= 0; m_retries <= 0; m_losses <= 0;
    end else begin
      lkm = (m_s2 != 0);
      ph  = m_phase;
      age = m_age + 1;
      run = lkm ? m_run + 1 : 0;
      rtr = m_retries;
      los = m_losses;
      if (relock_req) begin
        ph = 0; age = 0; rtr = 0;
      end else begin
        case (m_phase)
          0: if (age == RST) begin ph = 1; age = 0; end
          1: begin
            if (run == STAB) begin
              ph = 2; age = 0;
            end else if (age == TMO) begin
              age = 0;
              if (rtr < MAXR) begin rtr = rtr + 1; ph = 0; end
              else ph = 4;
            end
          end
          2, 3: begin
            if (!lkm) begin
              los = (los < 255) ? los + 1 : 255;
              rtr = 0; ph = 0; age = 0;
            end else if (m_phase == 2 && age == GAP) begin
              ph = 3; age = 0;
            end
          end
          default: age = 0;
        endcase
      end
      if (ph != 1 || m_phase != 1) run = 0;
      m_s2      <= m_s1;
      m_s1      <= pll_locked ? 1 : 0;
      m_phase   <= ph;
      m_age     <= age;
      m_run     <= run;
      m_retries <= rtr;
      m_losses  <= los;
    end
  end

  function automatic logic [19:0] model_vec();
    logic pr, px, sy, rd, lf;
    pr = (m_phase == 0) || (m_phase == 4);
    px = (m_phase == 2) || (m_phase == 3);
    sy = (m_phase == 3);
    rd = (m_phase == 3);
    lf = (m_phase == 4);
    return {pr, px, sy, rd, lf, 4'(m_retries), 8'(m_losses), 3'(m_phase)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", dut_vec, RST_VEC);
    end
    repeat (3) @(negedge refclk);
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_nominal();
    int k, fall_k, pix_k, sys_k;
    @(negedge refclk);
    rst_n = 1'b1;
    fall_k = -1; pix_k = -1; sys_k = -1;
    for (k = 1; k <= 200 && sys_k < 0; k++) begin
      @(negedge refclk);
      if (fall_k < 0 && !pll_rst) begin fall_k = k; pll_locked = 1'b1; end
      if (pix_k < 0 && pix_rst_n) pix_k = k;
      if (sys_k < 0 && sys_rst_n) sys_k = k;
    end
    checks++;
    if (fall_k != RST) begin
      errors++;
      $display("FAIL nominal_pulse_len got=%0d exp=%0d", fall_k, RST);
    end
    checks++;
    if (pix_k - fall_k != 2 + STAB) begin
      errors++;
      $display("FAIL nominal_pix_delay got=%0d exp=%0d", pix_k - fall_k, 2 + STAB);
    end
    checks++;
    if (sys_k - pix_k != GAP) begin
      errors++;
      $display("FAIL nominal_sys_gap got=%0d exp=%0d", sys_k - pix_k, GAP);
    end
    checks++;
    if ({ready, retry_cnt, state_o} !== {1'b1, 4'd0, 3'd3}) begin
      errors++;
      $display("FAIL nominal_run got=%b exp=%b", {ready, retry_cnt, state_o}, {1'b1, 4'd0, 3'd3});
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL nominal_model got=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_glitch();
    int k, fall_k, pix_k;
    @(negedge refclk);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    fall_k = -1;
    for (k = 1; k <= 20 && fall_k < 0; k++) begin
      @(negedge refclk);
      relock_req = 1'b0;
      if (!pll_rst) fall_k = k;
    end
    checks++;
    if (fall_k != RST + 1) begin
      errors++;
      $display("FAIL glitch_pulse got=%0d exp=%0d", fall_k, RST + 1);
    end
    pll_locked = 1'b1;
    pix_k = -1;
    for (k = 1; k <= 40; k++) begin
      @(negedge refclk);
      if (pix_k < 0 && pix_rst_n) pix_k = k;
      if (k == 6) pll_locked = 1'b0;
      if (k == 7) pll_locked = 1'b1;
    end
    checks++;
    if (pix_k != 7 + 2 + STAB) begin
      errors++;
      $display("FAIL glitch_pix_delay got=%0d exp=%0d", pix_k, 7 + 2 + STAB);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL glitch_run got=%b exp=1", ready);
    end
  endtask

  task automatic test_lock_loss();
    int k, drop_k;
    logic [2:0] snap;
    @(negedge refclk);
    pll_locked = 1'b0;
    drop_k = -1;
    snap = 3'b000;
    for (k = 1; k <= 8; k++) begin
      @(negedge refclk);
      if (k == 1) pll_locked = 1'b1;
      if (drop_k < 0 && !ready) begin
        drop_k = k;
        snap = {pll_rst, pix_rst_n, sys_rst_n};
      end
    end
    checks++;
    if (drop_k != 3) begin
      errors++;
      $display("FAIL loss_latency got=%0d exp=3", drop_k);
    end
    checks++;
    if (snap !== 3'b100) begin
      errors++;
      $display("FAIL loss_outputs got=%b exp=100", snap);
    end
    checks++;
    if (lock_loss_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_count got=%0d exp=1", lock_loss_cnt);
    end
    for (k = 0; k < 200 && !ready; k++) @(negedge refclk);
    checks++;
    if ({ready, retry_cnt} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL loss_relock got=%b exp=10000", {ready, retry_cnt});
    end
  endtask

  task automatic test_relock_vs_loss();
    int k;
    @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    checks++;
    if ({state_o, lock_loss_cnt} !== {3'd0, 8'd1}) begin
      errors++;
      $display("FAIL relock_vs_loss got=%h exp=%h", {state_o, lock_loss_cnt}, {3'd0, 8'd1});
    end
    for (k = 0; k < 200 && !ready; k++) @(negedge refclk);
    checks++;
    if ({ready, lock_loss_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL relock_vs_loss_run got=%h exp=%h", {ready, lock_loss_cnt}, {1'b1, 8'd1});
    end
  endtask

  task automatic test_timeout();
    int k, fail_k, len;
    int lens[$];
    int starts[$];
    logic prev_hi;
    @(negedge refclk);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    prev_hi = 1'b0;
    len = 0;
    fail_k = -1;
    for (k = 1; k <= 130; k++) begin
      @(negedge refclk);
      relock_req = 1'b0;
      if (fail_k < 0 && state_o == 3'd4) fail_k = k;
      if (fail_k < 0) begin
        if (pll_rst && !prev_hi) begin starts.push_back(int'(retry_cnt)); len = 1; end
        else if (pll_rst) len++;
        else if (prev_hi) lens.push_back(len);
        prev_hi = pll_rst;
      end
    end
    checks++;
    if (lens.size() != MAXR + 1 || starts.size() != MAXR + 1) begin
      errors++;
      $display("FAIL timeout_pulse_count got=%0d exp=%0d", lens.size(), MAXR + 1);
    end else begin
      for (int i = 0; i <= MAXR; i++) begin
        checks++;
        if (lens[i] != RST || starts[i] != i) begin
          errors++;
          $display("FAIL timeout_pulse%0d len=%0d retry=%0d exp len=%0d retry=%0d",
                   i, lens[i], starts[i], RST, i);
        end
      end
    end
    checks++;
    if (fail_k != (MAXR + 1) * (RST + TMO) + 1) begin
      errors++;
      $display("FAIL timeout_fail_time got=%0d exp=%0d", fail_k, (MAXR + 1) * (RST + TMO) + 1);
    end
    checks++;
    if ({lock_fail, pll_rst, ready, state_o, retry_cnt} !== {1'b1, 1'b1, 1'b0, 3'd4, 4'(MAXR)}) begin
      errors++;
      $display("FAIL timeout_fail_state got=%b exp=%b",
               {lock_fail, pll_rst, ready, state_o, retry_cnt}, {1'b1, 1'b1, 1'b0, 3'd4, 4'(MAXR)});
    end
  endtask

  task automatic test_relock_from_fail();
    int k, low_k;
    @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    checks++;
    if ({lock_fail, retry_cnt, state_o, pll_rst} !== {1'b0, 4'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL fail_relock got=%b exp=%b", {lock_fail, retry_cnt, state_o, pll_rst},
               {1'b0, 4'd0, 3'd0, 1'b1});
    end
    low_k = -1;
    for (k = 2; k <= 20 && low_k < 0; k++) begin
      @(negedge refclk);
      if (!pll_rst) low_k = k;
    end
    checks++;
    if (low_k - 1 != RST) begin
      errors++;
      $display("FAIL fail_relock_pulse got=%0d exp=%0d", low_k - 1, RST);
    end
    pll_locked = 1'b1;
    for (k = 0; k < 200 && !ready; k++) @(negedge refclk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL fail_relock_run got=%b exp=1", ready);
    end
  endtask

  task automatic test_random();
    int seg;
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, model_vec());
      end
      checks++;
      if (sys_rst_n && !pix_rst_n) begin
        errors++;
        $display("FAIL random_sys_pix cyc=%0d sys=%b pix=%b exp pix=1", c, sys_rst_n, pix_rst_n);
      end
      checks++;
      if (ready !== (state_o == 3'd3)) begin
        errors++;
        $display("FAIL random_ready cyc=%0d ready=%b state=%0d", c, ready, state_o);
      end
      checks++;
      if (pll_rst && !(state_o == 3'd0 || state_o == 3'd4)) begin
        errors++;
        $display("FAIL random_pll_rst cyc=%0d pll_rst=%b state=%0d", c, pll_rst, state_o);
      end
      if (seg == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        seg = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
      end
      seg--;
      relock_req = ($urandom_range(0, 79) == 0);
    end
    @(negedge refclk);
    relock_req = 1'b0;
  endtask

  task automatic test_async_reset();
    int k;
    bit found;
    @(negedge refclk);
    pll_locked = 1'b1;
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    found = 0;
    for (k = 0; k < 60 && !found; k++) begin
      @(negedge refclk);
      if (pix_rst_n && !sys_rst_n) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_reach_release got=0 exp=1");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, RST_VEC);
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_relock_vs_loss();
    test_timeout();
    test_relock_from_fail();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
